greater_than_cmp: RTL and testbench

- Registered magnitude comparator. Asserts F when operand A is strictly greater than operand B.
- Also provides equal and less-than flags for downstream decision logic.
- Default configuration is a 2-bit unsigned compare with one-cycle latency.
- Sits between operand-producing datapath logic and control logic that consumes compare flags.

---
 rtl/greater_than_cmp.sv | 53 +++++
 tb/tb_greater_than_cmp.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/greater_than_cmp.sv
// Registered magnitude comparator: flags A>B, A==B, A<B one cycle after a valid operand pair.
// No backpressure; a new pair is accepted every cycle. Flags hold their last value while idle.
module greater_than_cmp #(
  parameter int WIDTH  = 2,
  parameter bit SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  output logic             F,
  output logic             EQ,
  output logic             LT
);

  // One extra bit makes unsigned and two's-complement operands compare exactly as signed values.
  logic                    sign_a;
  logic                    sign_b;
  logic signed [WIDTH:0]   a_ext;
  logic signed [WIDTH:0]   b_ext;
  logic                    gt;
  logic                    eq;
  logic                    lt;

  assign sign_a = SIGNED ? A[WIDTH-1] : 1'b0;
  assign sign_b = SIGNED ? B[WIDTH-1] : 1'b0;
  assign a_ext  = {sign_a, A};
  assign b_ext  = {sign_b, B};

  assign gt = (a_ext > b_ext);
  assign eq = (a_ext == b_ext);
  assign lt = (a_ext < b_ext);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      F         <= 1'b0;
      EQ        <= 1'b0;
      LT        <= 1'b0;
    end else begin
      out_valid <= in_valid;
      // Operands are ignored while idle, so X on A/B cannot reach the flags.
      if (in_valid) begin
        F  <= gt;
        EQ <= eq;
        LT <= lt;
      end
    end
  end

endmodule

// File: tb/tb_greater_than_cmp.sv
// Scoreboard bench: three comparator configurations (2-bit unsigned, 2-bit signed, 8-bit unsigned)
// driven in lockstep; expected {out_valid,F,EQ,LT} per cycle is queued by a reference model.
module tb_greater_than_cmp;

  logic       clk;
  logic       rst_n;
  logic       v0, v1, v2;
  logic [1:0] a0, b0, a1, b1;
  logic [7:0] a2, b2;
  logic       ov0, f0, eq0, lt0;
  logic       ov1, f1, eq1, lt1;
  logic       ov2, f2, eq2, lt2;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [3:0] q0[$];
  logic [3:0] q1[$];
  logic [3:0] q2[$];
  logic [2:0] held[3];

  greater_than_cmp #(.WIDTH(2), .SIGNED(1'b0)) u_u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(v0), .A(a0), .B(b0),
    .out_valid(ov0), .F(f0), .EQ(eq0), .LT(lt0));

  greater_than_cmp #(.WIDTH(2), .SIGNED(1'b1)) u_s2 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .A(a1), .B(b1),
    .out_valid(ov1), .F(f1), .EQ(eq1), .LT(lt1));

  greater_than_cmp #(.WIDTH(8), .SIGNED(1'b0)) u_u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .A(a2), .B(b2),
    .out_valid(ov2), .F(f2), .EQ(eq2), .LT(lt2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: interpret operands as integers, then compare with ordinary arithmetic.
  function automatic logic [2:0] ref_cmp(input int a, input int b, input int w, input bit s);
    int va, vb;
    va = a;
    vb = b;
    if (s && va >= (1 << (w - 1))) va = va - (1 << w);
    if (s && vb >= (1 << (w - 1))) vb = vb - (1 << w);
    return {va > vb, va == vb, va < vb};
  endfunction

  task automatic model(input int i, input bit r, input bit v, input int x, input int y,
                       input int w, input bit s);
    logic [3:0] e;
    if (!r) begin
      held[i] = 3'b000;
      e = 4'b0000;
    end else if (v) begin
      held[i] = ref_cmp(x, y, w, s);
      e = {1'b1, held[i]};
    end else begin
      e = {1'b0, held[i]};
    end
    case (i)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic step(input bit r,
                      input bit s0, input int x0, input int y0,
                      input bit s1, input int x1, input int y1,
                      input bit s2, input int x2, input int y2);
    @(negedge clk);
    rst_n = r;
    v0 = s0; a0 = s0 ? x0[1:0] : 2'bxx; b0 = s0 ? y0[1:0] : 2'bxx;
    v1 = s1; a1 = s1 ? x1[1:0] : 2'bxx; b1 = s1 ? y1[1:0] : 2'bxx;
    v2 = s2; a2 = s2 ? x2[7:0] : 8'hxx; b2 = s2 ? y2[7:0] : 8'hxx;
    model(0, r, s0, x0, y0, 2, 1'b0);
    model(1, r, s1, x1, y1, 2, 1'b1);
    model(2, r, s2, x2, y2, 8, 1'b0);
  endtask

  task automatic compare(input int i, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL dut%0d cycle %0d: vld/F/EQ/LT got=%b expected=%b", i, cyc, got, exp);
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge and retires one expectation per DUT.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (q0.size() > 0) compare(0, {ov0, f0, eq0, lt0}, q0.pop_front());
    if (q1.size() > 0) compare(1, {ov1, f1, eq1, lt1}, q1.pop_front());
    if (q2.size() > 0) compare(2, {ov2, f2, eq2, lt2}, q2.pop_front());
  end

  task automatic rand_step(input bit r, input bit s0, input int x0, input int y0);
    step(r, s0, x0, y0,
         $urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
         $urandom_range(0, 3) != 0, $urandom_range(0, 255), $urandom_range(0, 255));
  endtask

  initial begin
    rst_n = 1'b0;
    v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0; a2 = '0; b2 = '0;
    for (int i = 0; i < 3; i++) held[i] = 3'b000;

    // Reset wins over a valid pair.
    repeat (2) step(1'b0, 1'b1, 3, 0, 1'b1, 1, 2, 1'b1, 255, 0);

    // Exhaustive 2-bit unsigned, back to back.
    for (int c = 0; c < 16; c++) rand_step(1'b1, 1'b1, c >> 2, c & 3);

    // Flags hold while idle; idle operands are X.
    rand_step(1'b1, 1'b1, 2, 1);
    rand_step(1'b1, 1'b0, 0, 3);
    rand_step(1'b1, 1'b0, 0, 3);

    // Mid-stream reset discards the pair presented with it.
    rand_step(1'b1, 1'b1, 1, 2);
    rand_step(1'b1, 1'b1, 3, 3);
    rand_step(1'b0, 1'b1, 3, 1);
    rand_step(1'b1, 1'b1, 3, 1);
    rand_step(1'b1, 1'b1, 0, 1);

    // Signed and wide boundary cases.
    step(1'b1, 1'b1, 3, 0, 1'b1, 1, 2, 1'b1, 255, 0);
    step(1'b1, 1'b1, 0, 3, 1'b1, 2, 1, 1'b1, 0, 255);
    step(1'b1, 1'b1, 2, 2, 1'b1, 3, 3, 1'b1, 128, 128);
    step(1'b1, 1'b1, 1, 1, 1'b1, 1, 1, 1'b1, 127, 128);

    // Random traffic with occasional resets.
    for (int n = 0; n < 300; n++)
      rand_step($urandom_range(0, 39) != 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 3), $urandom_range(0, 3));

    step(1'b1, 1'b0, 0, 0, 1'b0, 0, 0, 1'b0, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (q0.size() + q1.size() + q2.size() != 0) begin
      failures++;
      $display("FAIL drain: pending expectations got=%0d required=0",
               q0.size() + q1.size() + q2.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
